// File: rtl/baseline_pkg.sv
// baseline_pkg: shared constants, defaults and width helper for baseline_tracker
package baseline_pkg;
   localparam int MODE_FROZEN  = 0;
   localparam int MODE_SLIDING = 1;
   localparam int DEF_DIN_W  = 25;
   localparam int DEF_N0     = 5;
   localparam int DEF_N1     = 5;
   localparam int DEF_N2     = 6;
   localparam int DEF_HIST   = 8;
   localparam int DEF_BASE_N = 4;
   localparam int DEF_SHIFT  = 8;
   localparam int DEF_MODE   = MODE_FROZEN;
   function automatic int clog2w(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/baseline_tracker_decim_acc.sv
// decim_acc: non-overlapping window summer, emits one sum per N accepted inputs
module decim_acc
   import baseline_pkg::*;
#(
   parameter int W_IN  = 8,
   parameter int N     = 2,
   parameter int W_OUT = W_IN + clog2w(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [W_IN-1:0]  in,
   input  logic                    in_valid,
   output logic signed [W_OUT-1:0] out,
   output logic                    out_valid
);
   localparam int CW = clog2w(N);
   logic [CW-1:0] cnt;
   logic signed [W_OUT-1:0] acc;
   logic signed [W_OUT-1:0] sum;
   assign sum = acc + W_OUT'(in);
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            if (cnt == CW'(N - 1)) begin
               out       <= sum;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/baseline_tracker.sv
// baseline_tracker: three-level decimation, level-2 history and shifted baseline
// with frozen/sliding update modes and relock.
module baseline_tracker
   import baseline_pkg::*;
#(
   parameter int DIN_W  = DEF_DIN_W,
   parameter int N0     = DEF_N0,
   parameter int N1     = DEF_N1,
   parameter int N2     = DEF_N2,
   parameter int HIST   = DEF_HIST,
   parameter int BASE_N = DEF_BASE_N,
   parameter int SHIFT  = DEF_SHIFT,
   parameter int MODE   = DEF_MODE,
   localparam int W0     = DIN_W + clog2w(N0),
   localparam int W1     = W0 + clog2w(N1),
   localparam int W2     = W1 + clog2w(N2),
   localparam int DOUT_W = W2 + clog2w(BASE_N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DIN_W-1:0]  din,
   input  logic                     din_valid,
   input  logic                     en,
   input  logic                     relock,
   output logic signed [DOUT_W-1:0] dout,
   output logic                     dout_valid,
   output logic                     locked
);
   localparam int FW = clog2w(HIST + 1);
   logic signed [W0-1:0] l0;
   logic signed [W1-1:0] l1;
   logic signed [W2-1:0] l2;
   logic l0_v, l1_v, l2_v;
   logic signed [W2-1:0] hist [HIST];
   logic [FW-1:0] fill;
   logic full, upd;
   logic signed [DOUT_W-1:0] base_sum;
   decim_acc #(.W_IN(DIN_W), .N(N0), .W_OUT(W0)) u_l0 (
      .clk(clk), .rst(rst), .in(din), .in_valid(din_valid && !en), .out(l0), .out_valid(l0_v)
   );
   decim_acc #(.W_IN(W0), .N(N1), .W_OUT(W1)) u_l1 (
      .clk(clk), .rst(rst), .in(l0), .in_valid(l0_v), .out(l1), .out_valid(l1_v)
   );
   decim_acc #(.W_IN(W1), .N(N2), .W_OUT(W2)) u_l2 (
      .clk(clk), .rst(rst), .in(l1), .in_valid(l1_v), .out(l2), .out_valid(l2_v)
   );
   assign full = fill == FW'(HIST);
   always_comb begin
      base_sum = '0;
      for (int i = HIST - BASE_N; i < HIST; i++) base_sum += DOUT_W'(hist[i]);
   end
   // upd delays the dout update one cycle so the baseline sees the freshly shifted history
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < HIST; i++) hist[i] <= '0;
         fill       <= '0;
         upd        <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         locked     <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         upd        <= 1'b0;
         if (relock) begin
            for (int i = 0; i < HIST; i++) hist[i] <= '0;
            if (l2_v) hist[0] <= l2;
            fill   <= l2_v ? FW'(1) : '0;
            locked <= 1'b0;
         end else begin
            if (l2_v && !(MODE == MODE_FROZEN && full)) begin
               hist[0] <= l2;
               for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
               fill <= full ? fill : fill + 1'b1;
               upd  <= fill >= FW'(HIST - 1);
            end
            if (upd) begin
               dout       <= base_sum >>> SHIFT;
               dout_valid <= 1'b1;
               locked     <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_baseline_tracker.sv
// tb_baseline_tracker: directed table plus multi-cycle sequences for both baseline modes
module tb_baseline_tracker;
   typedef struct {
      int     din;
      longint exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_valid = 1'b0;
   logic en = 1'b0;
   logic relock = 1'b0;
   logic signed [24:0] din = '0;
   logic signed [35:0] dout0, dout1;
   logic dv0, dv1, lk0, lk1;
   baseline_tracker #(.MODE(0)) u0 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .en(en), .relock(relock),
      .dout(dout0), .dout_valid(dv0), .locked(lk0)
   );
   baseline_tracker #(.MODE(1)) u1 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .en(en), .relock(relock),
      .dout(dout1), .dout_valid(dv1), .locked(lk1)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int np0 = 0, np1 = 0, vc0 = -1, vc1 = -1, lc0 = -1;
   logic plk0 = 1'b0;
   longint q1 [$];
   int qc1 [$];
   always @(negedge clk) begin
      if (dv0) begin np0++; vc0 = cyc; end
      if (dv1) begin np1++; vc1 = cyc; q1.push_back(longint'(dout1)); qc1.push_back(cyc); end
      if (lk0 && !plk0) lc0 = cyc;
      plk0 = lk0;
   end
   int tests = 0, fails = 0, lastb = 0;
   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input int v);
      din = v[24:0];
      din_valid = 1'b1;
      en = 1'b0;
      lastb = cyc;
      tick();
   endtask
   task automatic idle(input int n);
      din_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic run(input int v, input int n);
      for (int i = 0; i < n; i++) beat(v);
   endtask
   task automatic do_rst();
      rst = 1'b1;
      din_valid = 1'b0;
      relock = 1'b0;
      en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask
   vec_t tbl [7];
   int s0, s1, qs;
   longint exp_q [9];
   initial begin
      tbl[0] = '{1, 2};
      tbl[1] = '{-256, -600};
      tbl[2] = '{-1, -3};
      tbl[3] = '{3, 7};
      tbl[4] = '{-5, -12};
      tbl[5] = '{16777215, 39321597};
      tbl[6] = '{-16777216, -39321600};
      exp_q = '{2, 2, 2, 2, 2, 3, 4, 5, 7};
      tick();
      do_rst();
      chk("reset dout0", dout0, 0);
      chk("reset dv0", dv0, 0);
      chk("reset locked0", lk0, 0);
      chk("reset dout1", dout1, 0);
      chk("reset dv1", dv1, 0);
      chk("reset locked1", lk1, 0);
      for (int i = 0; i < 7; i++) begin
         do_rst();
         s0 = np0; s1 = np1;
         run(tbl[i].din, 1200);
         idle(8);
         chk($sformatf("vec%0d pulses0", i), np0 - s0, 1);
         chk($sformatf("vec%0d latency0", i), vc0, lastb + 5);
         chk($sformatf("vec%0d dout0", i), dout0, tbl[i].exp);
         chk($sformatf("vec%0d locked0", i), lk0, 1);
         chk($sformatf("vec%0d lock_cycle0", i), lc0, vc0);
         chk($sformatf("vec%0d pulses1", i), np1 - s1, 1);
         chk($sformatf("vec%0d dout1", i), dout1, tbl[i].exp);
      end
      // frozen vs sliding after a level change
      do_rst();
      s0 = np0; qs = q1.size();
      run(1, 1200);
      run(3, 1200);
      idle(8);
      chk("frozen pulses", np0 - s0, 1);
      chk("frozen dout held", dout0, 2);
      chk("sliding pulses", q1.size() - qs, 9);
      if (q1.size() - qs == 9)
         for (int j = 0; j < 9; j++) begin
            chk($sformatf("sliding dout[%0d]", j), q1[qs+j], exp_q[j]);
            if (j > 0) chk($sformatf("sliding spacing[%0d]", j), qc1[qs+j] - qc1[qs+j-1], 150);
         end
      // gapped qualifier and a long en stall mid-window
      do_rst();
      s0 = np0;
      begin
         int c = 0, n = 0;
         while (n < 1200) begin
            if (c >= 333 && c < 433) begin
               en = 1'b1; din_valid = 1'b1; din = 25'sd999; tick();
            end else if (c % 2 == 1) begin
               en = 1'b0; din_valid = 1'b0; din = 25'sd777; tick();
            end else begin
               beat(2); n++;
            end
            c++;
         end
      end
      idle(8);
      chk("qual pulses", np0 - s0, 1);
      chk("qual latency", vc0, lastb + 5);
      chk("qual dout", dout0, 4);
      // relock on the same cycle as the third push after lock
      do_rst();
      run(1, 1200);
      for (int b = 1201; b <= 2700; b++) begin
         relock = (b == 1653);
         if (b == 1655) begin
            chk("relock clears locked0", lk0, 0);
            chk("relock clears locked1", lk1, 0);
            chk("relock holds dout0", dout0, 2);
            s0 = np0; s1 = np1;
         end
         beat(b <= 1650 ? 1 : 2);
      end
      relock = 1'b0;
      idle(8);
      chk("relock pulses0", np0 - s0, 1);
      chk("relock pulses1", np1 - s1, 1);
      chk("relock latency0", vc0, lastb + 5);
      chk("relock dout0", dout0, 4);
      chk("relock dout1", dout1, 4);
      chk("relock locked0", lk0, 1);
      // reset in the middle of a window
      run(1, 700);
      do_rst();
      chk("midrst dout0", dout0, 0);
      chk("midrst locked0", lk0, 0);
      chk("midrst dout1", dout1, 0);
      chk("midrst locked1", lk1, 0);
      s0 = np0;
      run(1, 1200);
      idle(8);
      chk("midrst pulses", np0 - s0, 1);
      chk("midrst latency", vc0, lastb + 5);
      chk("midrst dout", dout0, 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/baseline_tracker.md
# baseline_tracker

Parametrised successor to the fixed three-level baseline block. It decimates a signed feature stream through three cascaded non-overlapping window sums and keeps a HIST-deep history of level-2 sums. The baseline is the arithmetically shifted sum of the BASE_N oldest history entries. It sits between the feature extractor and the detection controller. It adds an input-valid qualifier, selectable frozen or sliding baseline modes, a lock/relock mechanism, and corrected valid semantics.

## Interface
- DIN_W, 25: input sample width, signed
- N0, 5: input samples per level-0 window (≥2)
- N1, 5: level-0 sums per level-1 window (≥2)
- N2, 6: level-1 sums per level-2 window (≥2)
- HIST, 8: history depth in level-2 sums
- BASE_N, 4: oldest entries summed for the baseline (1..HIST)
- SHIFT, 8: arithmetic right shift applied to the baseline sum
- MODE, 0: 0 = frozen (lock after first fill), 1 = sliding (update on every push once full)
- Derived widths: W0 = DIN_W+clog2(N0), W1 = W0+clog2(N1), W2 = W1+clog2(N2), DOUT_W = W2+clog2(BASE_N)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- din  in  DIN_W  signed sample
- din_valid  in  1  sample qualifier
- en  in  1  active-low input enable; while high, din is not accepted
- relock  in  1  one-cycle pulse; clears history and lock
- dout  out  DOUT_W  signed baseline, held between updates
- dout_valid  out  1  one-cycle pulse on each dout update
- locked  out  1  high once history has filled (MODE 0: stays high until relock/rst)

## Operation
- Input beat accepted when din_valid && !en.
- Each level has a counter (0..N−1) and an accumulator. On the beat where the counter reaches N−1:
  - the level registers acc+input as its output with a one-cycle valid pulse,
  - the accumulator restarts at 0 and the counter returns to 0.
- Level 1 consumes level-0 pulses. Level 2 consumes level-1 pulses.
- History is a shift register of HIST×W2. Each level-2 pulse pushes the new sum at the head; the oldest entry falls off the tail.
- A fill counter saturates at HIST.
- Baseline = sum of tail entries HIST−1 … HIST−BASE_N, computed in DOUT_W bits, then arithmetic shift >>> SHIFT. The result is sign-preserved and truncates toward −∞.
- MODE 0:
  - The push that makes fill==HIST computes dout, pulses dout_valid once, and sets locked.
  - After that, pushes are ignored and dout is held.
- MODE 1:
  - The push that fills history, and every push after it, updates dout and pulses dout_valid.
  - locked follows fill==HIST.
- relock:
  - Clears history, fill, and locked. dout holds its last value.
  - Level accumulators and counters are not disturbed.
  - relock concurrent with a history push: relock wins, and the pushed sum becomes entry 1 (fill=1).
- en high does not stall in-flight pulses. Level outputs already generated still propagate.
- No overflow is possible by width construction. No saturation logic.

## Timing
- Reset value of every output: dout=0, dout_valid=0, locked=0. All counters, accumulators, history, and fill are also 0.
- Latency from the accepted beat completing a level-2 window to dout_valid is 5 cycles:
  - L0 out at t+1, L1 at t+2, L2 at t+3,
  - history updated at t+4,
  - dout/dout_valid at t+5.
- locked rises in the same cycle as the first dout_valid.
- Back-to-back input beats are supported at full rate.
- Reset mid-window discards partial sums. The first window after reset starts at the first accepted beat.
- rst overrides relock and all other inputs.

## Structure
- Package baseline_pkg holds:
  - a clog2-based width function,
  - the MODE_FROZEN and MODE_SLIDING constants,
  - the default parameter values.
- Sub-module decim_acc: one non-overlapping window summer, parameters W_IN and N, with ports in/in_valid/out/out_valid. Instantiated three times.
- History, baseline adder tree, and lock logic live in the top module.

## Test plan
- Defaults, din=1 every cycle, 1200 beats -> L2 sum 150 per window; dout_valid once at beat 1200 + 5 cycles; dout=2 (600>>>8); locked=1; MODE 0 gives no further pulses over another 1200 beats.
- din=−256 constant -> L2 sum −38400; baseline −153600>>>8 = −600.
- din=−1 constant -> L2 sum −150; baseline −600>>>8 = −3 (floor); dout stays signed.
- MODE 1, din=1 for 1200 beats then din=3 -> dout_valid every 150 beats; dout stays 2 until the 4th push after the change has reached the tail region, then rises in steps 2→3→4→5→7 (sums 900, 1200, 1500, 1800 over 256 => 3, 4, 5, 7).
- din_valid toggled 50%, en high for 100 cycles mid-window -> only qualified beats counted; result identical to the contiguous case.
- relock coincident with the 3rd push after lock -> fill=1, locked=0; next lock after 7 more pushes; rst at beat 700 -> all outputs 0 and the count restarts.
